// File: rtl/std_dffe_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : std_dffe_pipe_pkg
// Brief    : Shared std width helpers used by the elastic register pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package std_dffe_pipe_pkg;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/std_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : std_pipe_stage
// Brief    : One elastic pipeline stage: valid + data register with load-enable.
// Revision : 1.0 - initial release
// ============================================================================
module std_pipe_stage
    import std_dffe_pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  ready_next,
    output logic                  ready_out,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_load;

    assign ready_out = !r_valid || ready_next;
    // Data only toggles when a real beat is captured, so idle stages hold still.
    assign w_load    = ready_out && in_valid && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VALUE;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (ready_out) begin
                r_valid <= in_valid;
            end
            if (w_load) begin
                r_data <= in_data;
            end
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/std_dffe_pipe.sv
`default_nettype none
// ============================================================================
// Module   : std_dffe_pipe
// Brief    : DEPTH-stage elastic register pipeline with valid/ready, flush, count.
// Revision : 1.0 - initial release
// ============================================================================
module std_dffe_pipe
    import std_dffe_pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 1,
    parameter int                    DEPTH       = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int c_cnt_w = count_width(DEPTH);

    logic [DEPTH-1:0]                 w_valid;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] w_data;
    logic [DEPTH-1:0]                 w_in_valid;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] w_in_data;
    logic [DEPTH:0]                   w_ready;
    logic [c_cnt_w-1:0]               w_count;

    // Ready ripples combinationally from the sink back to the source.
    assign w_ready[DEPTH] = m_ready;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            if (i == 0) begin : g_head
                assign w_in_valid[i] = s_valid;
                assign w_in_data[i]  = s_data;
            end else begin : g_body
                assign w_in_valid[i] = w_valid[i-1];
                assign w_in_data[i]  = w_data[i-1];
            end

            std_pipe_stage #(
                .DATA_WIDTH  (DATA_WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk        (clk),
                .resetn     (resetn),
                .flush      (flush),
                .in_valid   (w_in_valid[i]),
                .in_data    (w_in_data[i]),
                .ready_next (w_ready[i+1]),
                .ready_out  (w_ready[i]),
                .valid      (w_valid[i]),
                .data       (w_data[i])
            );
        end
    endgenerate

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + c_cnt_w'(w_valid[i]);
        end
    end

    assign s_ready = w_ready[0] && resetn;
    assign m_valid = w_valid[DEPTH-1];
    assign m_data  = w_data[DEPTH-1];
    assign count   = w_count;

endmodule
`default_nettype wire

// File: tb/tb_std_dffe_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_std_dffe_pipe
// Brief    : Self-checking bench for std_dffe_pipe (DEPTH=3 directed, DEPTH=1 random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_std_dffe_pipe;

    logic       clk;
    logic       resetn;
    logic       flush;
    logic       s_valid, s_ready, m_valid, m_ready;
    logic [7:0] s_data, m_data;
    logic [1:0] count;

    logic       s_valid1, s_ready1, m_valid1, m_ready1;
    logic [7:0] s_data1, m_data1;
    logic [0:0] count1;

    int checks = 0;
    int errors = 0;

    std_dffe_pipe #(.DATA_WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) u_dut3 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count)
    );

    std_dffe_pipe #(.DATA_WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00)) u_dut1 (
        .clk(clk), .resetn(resetn), .flush(1'b0),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .count(count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       fl;
        logic       e_sr;
        logic       e_mv;
        logic [7:0] e_md;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[17];

    logic [7:0] q[$];
    logic [7:0] next_val;
    logic [7:0] exp_v;
    logic       pending;

    initial begin
        // Expected outputs are observed before the edge of the same row.
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd1};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd2};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3};
        vecs[4]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd3};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2'd3};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 2'd2};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 2'd1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 2'd0};
        vecs[9]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 2'd0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 2'd1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 2'd1};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 2'd1};
        vecs[13] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 2'd1};
        vecs[14] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 2'd2};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 2'd0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 2'd0};

        resetn = 1'b0; flush = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        s_valid1 = 1'b0; s_data1 = 8'h00; m_ready1 = 1'b0;

        // Reset, then fill three stages so the mid-clock reset has beats to discard.
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("s_ready_after_release", 32'(s_ready), 32'd1);
        chk("count_after_release", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 8'hAA + 8'(i);
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("prefill_m_valid", 32'(m_valid), 32'd1);
        chk("prefill_m_data", 32'(m_data), 32'hAA);
        chk("prefill_count", 32'(count), 32'd3);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_m_valid", 32'(m_valid), 32'd0);
        chk("async_rst_m_data", 32'(m_data), 32'hA5);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_s_ready", 32'(s_ready), 32'd0);
        chk("async_rst_s_ready1", 32'(s_ready1), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("s_ready_after_rerelease", 32'(s_ready), 32'd1);

        // Backpressure, bubble collapse and flush rows.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            s_valid = vecs[i].sv; s_data = vecs[i].sd;
            m_ready = vecs[i].mr; flush = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
            chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_md));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
        end

        // Streaming 01..10 with m_ready high: beat k shows up in cycle k+2.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            flush = 1'b0; m_ready = 1'b1;
            s_valid = (k < 16); s_data = (k < 16) ? 8'(k + 1) : 8'h00;
            #1;
            chk($sformatf("stream%0d_s_ready", k), 32'(s_ready), 32'd1);
            chk($sformatf("stream%0d_m_valid", k), 32'(m_valid), 32'((k >= 3) && (k <= 18)));
            if (k >= 3 && k <= 18)
                chk($sformatf("stream%0d_m_data", k), 32'(m_data), 32'(k - 2));
            chk($sformatf("stream%0d_count", k), 32'(count),
                32'((k < 3) ? k : ((k <= 16) ? 3 : 19 - k)));
        end
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0;

        // DEPTH=1: random handshakes against a queue scoreboard.
        next_val = 8'h00;
        pending  = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (!pending) begin
                s_valid1 = 1'($urandom_range(0, 1));
                s_data1  = next_val;
            end
            m_ready1 = 1'($urandom_range(0, 1));
            #1;
            chk("d1_count", 32'(count1), 32'(q.size()));
            chk("d1_s_ready", 32'(s_ready1), 32'((q.size() == 0) || m_ready1));
            chk("d1_m_valid", 32'(m_valid1), 32'(q.size() != 0));
            if (m_valid1 && m_ready1) begin
                if (q.size() == 0) begin
                    chk("d1_pop_empty", 32'd1, 32'd0);
                end else begin
                    exp_v = q.pop_front();
                    chk("d1_order", 32'(m_data1), 32'(exp_v));
                end
            end
            if (s_valid1 && s_ready1) begin
                q.push_back(s_data1);
                next_val = next_val + 8'd1;
                pending  = 1'b0;
            end else begin
                pending  = s_valid1;
            end
        end
        @(negedge clk);
        s_valid1 = 1'b0;
        m_ready1 = 1'b0;
        #1;
        chk("d1_final_count", 32'(count1), 32'(q.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/std_dffe_pipe.md
# std_dffe_pipe

Parametrised elastic register pipeline, the successor of the single-stage enabled DFF. It is a chain of DEPTH data registers with per-stage valid bits, a valid/ready handshake at both ends, bubble collapsing, synchronous flush and an occupancy count. It is used wherever a datapath needs N cycles of retiming that must stall under downstream backpressure, such as decode-to-issue and writeback staging.

## Interface
- DATA_WIDTH, 1, payload width in bits (>=1)
- DEPTH, 2, number of register stages (>=1)
- RESET_VALUE, 0, value loaded into every data register on reset (DATA_WIDTH bits)
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline clear
- s_valid  in  1  upstream beat present
- s_ready  out  1  pipeline accepts the upstream beat this cycle
- s_data  in  DATA_WIDTH  upstream payload
- m_valid  out  1  output stage holds a beat
- m_ready  in  1  downstream accepts the output beat
- m_data  out  DATA_WIDTH  output payload, which is stage DEPTH-1
- count  out  $clog2(DEPTH+1)  number of valid stages

There is one clock. Reset is asynchronous and active-low.

## Operation
- Stages are indexed 0 (input) to DEPTH-1 (output). Each stage holds valid_i and data_i.
- ready_DEPTH = m_ready. ready_i = !valid_i || ready_{i+1}. s_ready = ready_0 && resetn.
- The ready path from m_ready to s_ready is combinational by design. No skid buffer.
- On an edge with ready_i=1: valid_i <= in_valid_i, where in_valid_0 = s_valid and in_valid_i = valid_{i-1}.
- data_i <= in_data_i only when ready_i && in_valid_i. Otherwise data_i holds, which gates power.
- With ready_i=0, the stage holds both valid and data.
- Bubble collapsing: a beat advances into any empty stage even while m_ready=0.
- Handshakes: input beat accepted iff s_valid && s_ready. Output beat delivered iff m_valid && m_ready.
- m_valid = valid_{DEPTH-1}. m_data = data_{DEPTH-1}. Both are driven directly from registers.
- count = popcount(valid_0..valid_{DEPTH-1}). It is combinational from registers only.
- flush has priority over the handshake rules. At the next edge every valid_i <= 0 and data is unchanged.
  - An output handshake in the flush cycle counts as delivered.
  - An input beat accepted in the flush cycle is discarded.
- s_valid must stay high with stable s_data until accepted. The block does not check this.

## Timing
- Reset, asynchronous on resetn low:
  - every valid_i = 0 and every data_i = RESET_VALUE
  - m_valid = 0, m_data = RESET_VALUE, count = 0
  - s_ready = 0 while resetn is low, and 1 on the first cycle after release
- Latency: a beat accepted at edge t appears on m_valid/m_data after edge t+DEPTH-1, assuming no stall. Stage 0 loads at edge t.
- Throughput: one beat per cycle with m_ready held high, for any DEPTH including 1.
- Full: all DEPTH stages valid and m_ready=0 gives s_ready=0 and count=DEPTH.
- Simultaneous push and pop when full: m_ready=1 gives s_ready=1 in the same cycle. Count stays DEPTH.
- Empty: count=0, m_valid=0, s_ready=1.
- Reset mid-operation discards all beats immediately, without waiting for a clock edge.
- Flush with resetn low: reset dominates.

## Structure
- No new typedefs. The count width helper ($clog2(DEPTH+1)) lives in the shared std constants header with the other width functions.
- Sub-module std_pipe_stage: one valid+data register pair with load-enable and flush, taking ports in_valid, in_data, ready_out, and valid, data.
- The top level is a generate loop of DEPTH std_pipe_stage instances, the ready chain, and the popcount.

## Test plan
- Reset, with DATA_WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5.
  - Assert resetn low mid-clock: m_valid=0, m_data=8'hA5, count=0 and s_ready=0 at once.
  - After release: s_ready=1.
- Streaming, with m_ready=1.
  - Push 8'h01..8'h10 on consecutive cycles: 8'h01 appears on m_data 2 edges after acceptance.
  - Order is preserved with no bubbles, and count=3 in steady state.
- Backpressure, with m_ready=0.
  - Offer 4 beats: 3 are accepted, s_ready drops after the third, count=3.
  - Raise m_ready: beat 4 is accepted in the same cycle beat 1 is delivered.
- Bubble collapse, with m_ready=0.
  - Push a single 8'h5A: it reaches the output stage 2 edges after acceptance.
  - count=1 and s_ready stays 1 throughout.
- Flush, with 2 stages valid.
  - Assert flush together with s_valid=1 and m_ready=1: the output beat counts as delivered.
  - Next cycle: count=0 and m_valid=0, and the input beat never emerges.
- DEPTH=1 with random m_ready/s_valid for 10k cycles: the scoreboard shows no loss, duplication or reordering, and count never exceeds 1.
